// File: rtl/airlock_transit_tracker_if.sv
// Request, door and status bundle between the door controllers,
// the transit tracker and the display logic.
interface airlock_transit_tracker_if #(
    parameter int NUM_CHAMBERS = 2,
    parameter int POS_W        = 4
);
    logic                    arriving;
    logic                    departing;
    logic [NUM_CHAMBERS:0]   door_open;
    logic [POS_W-1:0]        position;
    logic                    in_chamber;
    logic                    dwell_done;
    logic                    moved;
    logic                    blocked;
    logic                    interlock_fault;

    modport master (
        output arriving, departing, door_open,
        input  position, in_chamber, dwell_done,
        input  moved, blocked, interlock_fault
    );

    modport slave (
        input  arriving, departing, door_open,
        output position, in_chamber, dwell_done,
        output moved, blocked, interlock_fault
    );
endinterface

// File: rtl/airlock_transit_tracker.sv
// Tracks one vessel through a chain of airlock chambers, with a
// per-chamber dwell timer, door interlock fault and refusal pulses.
module airlock_transit_tracker #(
    parameter int NUM_CHAMBERS = 2,
    parameter int DWELL_CYCLES = 8,
    parameter int POS_W        = 4,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic reset,
    airlock_transit_tracker_if.slave bus
);
    localparam logic [POS_W-1:0] P_ABSENT  = '0;
    localparam logic [POS_W-1:0] P_OUTSIDE = POS_W'(1);
    localparam logic [POS_W-1:0] P_FIRST   = POS_W'(2);
    localparam logic [POS_W-1:0] P_LAST    = POS_W'(NUM_CHAMBERS + 1);
    localparam logic [POS_W-1:0] P_INSIDE  = POS_W'(NUM_CHAMBERS + 2);
    localparam logic [CNT_W-1:0] DWELL     = CNT_W'(DWELL_CYCLES);

    logic [POS_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             moved_q, moved_d;
    logic             blocked_q, blocked_d;
    logic             fault_q, fault_d;

    logic [POS_W-1:0] k_now, k_next;
    logic [1:0]       pair_now, pair_next;
    logic             in_ch, dwell_ok, exit_ok;
    logic             valid_req, unused_enc;

    function automatic logic is_chamber(input logic [POS_W-1:0] p);
        return (p >= P_FIRST) && (p <= P_LAST);
    endfunction

    always_comb begin
        in_ch      = is_chamber(pos_q);
        dwell_ok   = !in_ch || (cnt_q == DWELL);
        exit_ok    = dwell_ok && !fault_q;
        valid_req  = bus.arriving ^ bus.departing;
        unused_enc = pos_q > P_INSIDE;
        // pair[0] is the outer door of chamber k, pair[1] the inner one
        k_now      = pos_q - P_FIRST;
        pair_now   = 2'(bus.door_open >> k_now);

        pos_d     = pos_q;
        blocked_d = 1'b0;
        if (unused_enc) begin
            pos_d = P_ABSENT;
        end else if (valid_req) begin
            unique case (1'b1)
                pos_q == P_ABSENT: begin
                    pos_d = bus.arriving ? P_OUTSIDE : P_INSIDE;
                end
                pos_q == P_OUTSIDE: begin
                    if (bus.departing)         pos_d = P_ABSENT;
                    else if (bus.door_open[0]) pos_d = P_FIRST;
                    else                       blocked_d = 1'b1;
                end
                pos_q == P_INSIDE: begin
                    if (bus.arriving)                     pos_d = P_ABSENT;
                    else if (bus.door_open[NUM_CHAMBERS]) pos_d = P_LAST;
                    else                                  blocked_d = 1'b1;
                end
                default: begin
                    if (bus.arriving && pair_now[1] && exit_ok)
                        pos_d = pos_q + POS_W'(1);
                    else if (bus.departing && pair_now[0] && exit_ok)
                        pos_d = pos_q - POS_W'(1);
                    else
                        blocked_d = 1'b1;
                end
            endcase
        end

        moved_d = (pos_d != pos_q) && !unused_enc;

        // Fault reflects the chamber occupied after this edge
        k_next    = pos_d - P_FIRST;
        pair_next = 2'(bus.door_open >> k_next);
        fault_d   = is_chamber(pos_d) && pair_next[0] && pair_next[1];

        if (!is_chamber(pos_d) || (pos_d != pos_q)) cnt_d = '0;
        else if (cnt_q != DWELL)                    cnt_d = cnt_q + CNT_W'(1);
        else                                        cnt_d = cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q     <= P_ABSENT;
            cnt_q     <= '0;
            moved_q   <= 1'b0;
            blocked_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            pos_q     <= pos_d;
            cnt_q     <= cnt_d;
            moved_q   <= moved_d;
            blocked_q <= blocked_d;
            fault_q   <= fault_d;
        end
    end

    assign bus.position        = pos_q;
    assign bus.in_chamber      = in_ch;
    assign bus.dwell_done      = dwell_ok;
    assign bus.moved           = moved_q;
    assign bus.blocked         = blocked_q;
    assign bus.interlock_fault = fault_q;
endmodule

// File: tb/tb_airlock_transit_tracker.sv
// Directed vector table plus async-reset sequence for the tracker
// with two chambers and a four-cycle dwell.
module tb_airlock_transit_tracker;
    typedef struct {
        logic       arr;
        logic       dep;
        logic [2:0] door;
        logic [3:0] pos;
        logic       inch;
        logic       done;
        logic       mv;
        logic       blk;
        logic       flt;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    airlock_transit_tracker_if #(.NUM_CHAMBERS(2), .POS_W(4)) bus ();

    airlock_transit_tracker #(
        .NUM_CHAMBERS(2),
        .DWELL_CYCLES(4),
        .POS_W(4),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int idx,
                         input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d",
                     nm, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [3:0] pos,
                             input logic inch, input logic done,
                             input logic mv, input logic blk,
                             input logic flt);
        check("position", idx, int'(bus.position), int'(pos));
        check("in_chamber", idx, int'(bus.in_chamber), int'(inch));
        check("dwell_done", idx, int'(bus.dwell_done), int'(done));
        check("moved", idx, int'(bus.moved), int'(mv));
        check("blocked", idx, int'(bus.blocked), int'(blk));
        check("fault", idx, int'(bus.interlock_fault), int'(flt));
    endtask

    task automatic add(input logic a, input logic d, input logic [2:0] dr,
                       input logic [3:0] p, input logic ic, input logic dn,
                       input logic m, input logic b, input logic f);
        vec_t v;
        v.arr = a; v.dep = d; v.door = dr;
        v.pos = p; v.inch = ic; v.done = dn;
        v.mv = m; v.blk = b; v.flt = f;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // arr dep door  | pos inch done mv blk flt
        add(1, 0, 3'b000, 1, 0, 1, 1, 0, 0);
        add(1, 0, 3'b001, 2, 1, 0, 1, 0, 0);
        add(1, 0, 3'b010, 2, 1, 0, 0, 1, 0);
        add(1, 0, 3'b010, 2, 1, 0, 0, 1, 0);
        add(1, 0, 3'b010, 2, 1, 0, 0, 1, 0);
        add(1, 0, 3'b010, 2, 1, 1, 0, 1, 0);
        add(1, 0, 3'b010, 3, 1, 0, 1, 0, 0);
        add(0, 0, 3'b000, 3, 1, 0, 0, 0, 0);
        add(0, 0, 3'b000, 3, 1, 0, 0, 0, 0);
        add(0, 0, 3'b000, 3, 1, 0, 0, 0, 0);
        add(0, 0, 3'b000, 3, 1, 1, 0, 0, 0);
        add(0, 0, 3'b110, 3, 1, 1, 0, 0, 1);
        add(1, 0, 3'b110, 3, 1, 1, 0, 1, 1);
        add(0, 0, 3'b100, 3, 1, 1, 0, 0, 0);
        add(1, 0, 3'b100, 4, 0, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) add(1, 1, 3'b111, 4, 0, 1, 0, 0, 0);
        add(0, 1, 3'b000, 4, 0, 1, 0, 1, 0);
        add(0, 1, 3'b100, 3, 1, 0, 1, 0, 0);
        add(0, 0, 3'b000, 3, 1, 0, 0, 0, 0);
        add(0, 0, 3'b000, 3, 1, 0, 0, 0, 0);
        add(0, 0, 3'b000, 3, 1, 0, 0, 0, 0);
        add(0, 0, 3'b000, 3, 1, 1, 0, 0, 0);
        add(1, 0, 3'b100, 4, 0, 1, 1, 0, 0);
        add(1, 0, 3'b000, 0, 0, 1, 1, 0, 0);
        add(0, 1, 3'b000, 4, 0, 1, 1, 0, 0);
        add(1, 0, 3'b000, 0, 0, 1, 1, 0, 0);
        add(1, 0, 3'b000, 1, 0, 1, 1, 0, 0);
        add(1, 0, 3'b000, 1, 0, 1, 0, 1, 0);
        add(0, 1, 3'b000, 0, 0, 1, 1, 0, 0);
        add(1, 0, 3'b000, 1, 0, 1, 1, 0, 0);
        add(1, 0, 3'b001, 2, 1, 0, 1, 0, 0);
        add(0, 0, 3'b000, 2, 1, 0, 0, 0, 0);
        add(0, 0, 3'b000, 2, 1, 0, 0, 0, 0);
        add(0, 0, 3'b000, 2, 1, 0, 0, 0, 0);
        add(0, 0, 3'b000, 2, 1, 1, 0, 0, 0);
        add(0, 1, 3'b001, 1, 0, 1, 1, 0, 0);
        add(1, 0, 3'b011, 2, 1, 0, 1, 0, 1);

        bus.arriving  = 1'b0;
        bus.departing = 1'b0;
        bus.door_open = 3'b000;
        step();
        step();
        reset = 1'b0;
        check_all(-1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            bus.arriving  = vecs[i].arr;
            bus.departing = vecs[i].dep;
            bus.door_open = vecs[i].door;
            step();
            check_all(i, vecs[i].pos, vecs[i].inch, vecs[i].done,
                      vecs[i].mv, vecs[i].blk, vecs[i].flt);
        end

        // Async reset mid-cycle from chamber 0 with moved and fault set
        bus.arriving  = 1'b0;
        bus.departing = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check_all(100, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        bus.arriving  = 1'b1;
        bus.door_open = 3'b000;
        step();
        check_all(101, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
